bigmul_unit_pipe: RTL



---
 rtl/bigmul_pkg.sv | 23 ++
 rtl/bigmul_unit_pipe_lane_adder.sv | 33 +++
 rtl/bigmul_unit_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bigmul_pkg.sv
// Shared state type, accumulator sizing and column-bound helpers for the
// product-scanning big-integer multiplier.
package bigmul_pkg;

  typedef enum logic [1:0] {IDLE, COL, FLUSH} state_t;

  localparam int IDX_W = 16;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic int acc_w(input int word_w, input int nwords);
    return 2*word_w + $clog2(nwords) + 2;
  endfunction

  // First row index contributing to column s of an n-word product.
  function automatic idx_t col_imin(input idx_t s, input idx_t n);
    return (s >= n) ? s - n + idx_t'(1) : '0;
  endfunction

  function automatic idx_t col_imax(input idx_t s, input idx_t n);
    return (s < n) ? s : n - idx_t'(1);
  endfunction

endpackage

// File: rtl/bigmul_unit_pipe_lane_adder.sv
// LANES-way WORD_W x WORD_W multiply with per-lane masking, summed to ACC_W.
// BIGMUL_SQUARE_EN adds a per-lane doubling mask for the off-diagonal terms.
module bigmul_lane_adder #(
  parameter int WORD_W = 64,
  parameter int LANES  = 4,
  parameter int ACC_W  = 136
) (
`ifdef BIGMUL_SQUARE_EN
  input  logic [LANES-1:0]             dbl,
`endif
  input  logic [LANES-1:0][WORD_W-1:0] a_w,
  input  logic [LANES-1:0][WORD_W-1:0] b_w,
  input  logic [LANES-1:0]             valid,
  output logic [ACC_W-1:0]             sum
);
  localparam int PW = 2*WORD_W;

  logic [LANES-1:0][PW-1:0] prod;

  always_comb begin
    prod = '0;
    sum  = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = valid[l] ? PW'(a_w[l]) * PW'(b_w[l]) : '0;
`ifdef BIGMUL_SQUARE_EN
      sum = sum + (dbl[l] ? (ACC_W'(prod[l]) << 1) : ACC_W'(prod[l]));
`else
      sum = sum + ACC_W'(prod[l]);
`endif
    end
  end

endmodule

// File: rtl/bigmul_unit_pipe.sv
// Column-wise big-integer multiplier with operand/result caches and a
// start/busy/done handshake. Optional squaring mode under BIGMUL_SQUARE_EN.
//   state | meaning
//   IDLE  | waiting for start, caches writable
//   COL   | summing LANES partial products per cycle into the current column
//   FLUSH | writing the final carry word
module bigmul_unit_pipe
  import bigmul_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int NWORDS = 64,
  parameter int LANES  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [$clog2(NWORDS):0]     operand_size,
  input  logic                        sq_mode,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  input  logic                        a_we,
  input  logic [$clog2(NWORDS)-1:0]   a_waddr,
  input  logic [WORD_W-1:0]           a_wdata,
  input  logic                        b_we,
  input  logic [$clog2(NWORDS)-1:0]   b_waddr,
  input  logic [WORD_W-1:0]           b_wdata,
  input  logic [$clog2(2*NWORDS)-1:0] r_raddr,
  output logic [WORD_W-1:0]           r_rdata
);
  localparam int AW    = $clog2(NWORDS);
  localparam int RW    = $clog2(2*NWORDS);
  localparam int ACC_W = acc_w(WORD_W, NWORDS);

  logic [WORD_W-1:0] a_mem [NWORDS];
  logic [WORD_W-1:0] b_mem [NWORDS];
  logic [WORD_W-1:0] r_mem [2*NWORDS];

  state_t state, state_nxt;
  idx_t n_q, s_q, k_q, n_in, i_top, li;
  logic [AW-1:0] lj;
  logic [RW-1:0] flush_addr;
  logic sq_q, start_ok, start_bad, last_chunk, s_last;
  logic [ACC_W-1:0] acc_q, acc_sum, lane_sum;
  logic [LANES-1:0][WORD_W-1:0] a_lane, b_lane;
  logic [LANES-1:0] lane_v;

  assign busy       = (state != IDLE);
  assign n_in       = idx_t'(operand_size);
  assign start_ok   = start && (n_in != '0) && (n_in <= idx_t'(NWORDS));
  assign start_bad  = start && !start_ok;
  assign acc_sum    = acc_q + lane_sum;
  assign flush_addr = RW'((n_q << 1) - idx_t'(1));

`ifdef BIGMUL_SQUARE_EN
  logic [LANES-1:0] lane_dbl;

  always_ff @(posedge clk) begin
    if (!rstn)
      sq_q <= 1'b0;
    else if (state == IDLE && start_ok)
      sq_q <= sq_mode;
  end

  // Off-diagonal terms (i < j) stand in for their mirrored partner.
  always_comb begin
    lane_dbl = '0;
    for (int l = 0; l < LANES; l++)
      lane_dbl[l] = sq_q && (((k_q + idx_t'(l)) << 1) < s_q);
  end
`else
  logic unused_sq_mode;
  assign unused_sq_mode = sq_mode;
  assign sq_q = 1'b0;
`endif

  always_comb begin
    i_top = col_imax(s_q, n_q);
    if (sq_q && ((s_q >> 1) < i_top))
      i_top = s_q >> 1;
    last_chunk = (k_q + idx_t'(LANES)) > i_top;
    s_last     = (s_q == (n_q << 1) - idx_t'(2));
    li     = '0;
    lj     = '0;
    a_lane = '0;
    b_lane = '0;
    lane_v = '0;
    for (int l = 0; l < LANES; l++) begin
      li        = k_q + idx_t'(l);
      lj        = AW'(s_q - li);
      lane_v[l] = (li <= i_top);
      a_lane[l] = a_mem[li[AW-1:0]];
      b_lane[l] = sq_q ? a_mem[lj] : b_mem[lj];
    end
  end

  bigmul_lane_adder #(.WORD_W(WORD_W), .LANES(LANES), .ACC_W(ACC_W)) u_lanes (
`ifdef BIGMUL_SQUARE_EN
    .dbl   (lane_dbl),
`endif
    .a_w   (a_lane),
    .b_w   (b_lane),
    .valid (lane_v),
    .sum   (lane_sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = COL;
      COL:     if (last_chunk && s_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FLUSH);
      error <= (state == IDLE) && start_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
      n_q   <= '0;
      s_q   <= '0;
      k_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          n_q   <= n_in;
          acc_q <= '0;
          s_q   <= '0;
          k_q   <= '0;
        end
        COL: if (last_chunk) begin
          acc_q <= acc_sum >> WORD_W;
          s_q   <= s_q + idx_t'(1);
          k_q   <= col_imin(s_q + idx_t'(1), n_q);
        end else begin
          acc_q <= acc_sum;
          k_q   <= k_q + idx_t'(LANES);
        end
        default: ;
      endcase
    end
  end

  // Operand caches survive reset and are frozen while computing.
  always_ff @(posedge clk) begin
    if (a_we && !busy) a_mem[a_waddr] <= a_wdata;
    if (b_we && !busy) b_mem[b_waddr] <= b_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int w = 0; w < 2*NWORDS; w++) r_mem[w] <= '0;
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[r_raddr];
      if (state == IDLE && start_ok) begin
        for (int w = 0; w < 2*NWORDS; w++) r_mem[w] <= '0;
      end else if (state == COL && last_chunk) begin
        r_mem[s_q[RW-1:0]] <= acc_sum[WORD_W-1:0];
      end else if (state == FLUSH) begin
        r_mem[flush_addr] <= acc_q[WORD_W-1:0];
      end
    end
  end

endmodule
